key_capture: RTL and testbench

- Input stage directly upstream of the CPU read mux's key source.
- Synchronises and debounces the four raw direction buttons (w, a, s, d) and detects press edges.
- Holds a "last key" byte that the CPU reads at a fixed zero-page address. The CPU clears it by writing that address.
- Runs in the slow CPU clock domain, so debounce counts are in CPU cycles.

---
 rtl/key_capture.sv | 105 ++++++++++
 tb/tb_key_capture.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_capture.sv
// Direction-button input stage: 2-flop synchroniser, per-key debounce, press-edge detect,
// and a CPU-clearable last-key byte with a valid flag.
module key_capture #(
  parameter int unsigned DEBOUNCE   = 2,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter logic [15:0] KEY_ADDR   = 16'h00FF,
  parameter logic [7:0]  CODE_W     = 8'h77,
  parameter logic [7:0]  CODE_A     = 8'h61,
  parameter logic [7:0]  CODE_S     = 8'h73,
  parameter logic [7:0]  CODE_D     = 8'h64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w,
  input  logic        a,
  input  logic        s,
  input  logic        d,
  input  logic [15:0] cpu_address,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_data_write,
  output logic [7:0]  last_key,
  output logic        key_valid,
  output logic [3:0]  key_held
);

  localparam int unsigned      CntW   = $clog2(DEBOUNCE + 1);
  localparam logic [CntW-1:0]  CntMax = CntW'(DEBOUNCE - 1);

  logic [3:0]      raw;
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      stable_q, stable_d;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];
  logic [3:0]      press;
  logic [7:0]      last_key_q, last_key_d;
  logic            key_valid_q, key_valid_d;

  // Bit 3 = w ... bit 0 = d; normalised so 1 = pressed.
  assign raw = {w, a, s, d} ^ {4{ACTIVE_LOW}};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = stable_d & ~stable_q;

  // A press this edge outranks a CPU clear on the same edge.
  always_comb begin
    last_key_d  = last_key_q;
    key_valid_d = key_valid_q;
    if (press[3]) begin
      last_key_d  = CODE_W;
      key_valid_d = 1'b1;
    end else if (press[2]) begin
      last_key_d  = CODE_A;
      key_valid_d = 1'b1;
    end else if (press[1]) begin
      last_key_d  = CODE_S;
      key_valid_d = 1'b1;
    end else if (press[0]) begin
      last_key_d  = CODE_D;
      key_valid_d = 1'b1;
    end else if (cpu_we && (cpu_address == KEY_ADDR)) begin
      last_key_d  = cpu_data_write;
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      last_key_q  <= '0;
      key_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      last_key_q  <= last_key_d;
      key_valid_q <= key_valid_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign last_key  = last_key_q;
  assign key_valid = key_valid_q;
  assign key_held  = stable_q;

endmodule

// File: tb/tb_key_capture.sv
// Scoreboard bench for key_capture: stimulus pushes the expected output state and the edge it
// must first appear on; monitors pop and compare whenever the DUT outputs change.
module tb_key_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        w, a, s, d;
  logic [15:0] cpu_address;
  logic        cpu_we;
  logic [7:0]  cpu_data_write;
  logic [7:0]  last_key;
  logic        key_valid;
  logic [3:0]  key_held;

  logic        w1, a1, s1, d1;
  logic [7:0]  last_key1;
  logic        key_valid1;
  logic [3:0]  key_held1;

  key_capture dut (
    .clk            (clk),
    .rst            (rst),
    .w              (w),
    .a              (a),
    .s              (s),
    .d              (d),
    .cpu_address    (cpu_address),
    .cpu_we         (cpu_we),
    .cpu_data_write (cpu_data_write),
    .last_key       (last_key),
    .key_valid      (key_valid),
    .key_held       (key_held)
  );

  key_capture #(.DEBOUNCE(1)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .w              (w1),
    .a              (a1),
    .s              (s1),
    .d              (d1),
    .cpu_address    (16'h0000),
    .cpu_we         (1'b0),
    .cpu_data_write (8'h00),
    .last_key       (last_key1),
    .key_valid      (key_valid1),
    .key_held       (key_held1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    int         cyc;
    logic [7:0] lk;
    logic       v;
    logic [3:0] held;
  } ev_t;

  ev_t sb [$];
  ev_t sb1 [$];

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int ev_id    = 0;
  bit mon_en   = 1'b0;

  logic [12:0] prev, cur, prev1, cur1;

  always @(posedge clk) edge_n++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input bit which, input int cyc, input logic [7:0] lk,
                           input logic v, input logic [3:0] held);
    ev_t e;
    e = '{id: ev_id, cyc: cyc, lk: lk, v: v, held: held};
    ev_id++;
    if (which) sb1.push_back(e);
    else sb.push_back(e);
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    cpu_we         = 1'b1;
    cpu_address    = addr;
    cpu_data_write = data;
    step(1);
    cpu_we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cur = {last_key, key_valid, key_held};
      if (cur !== prev) begin
        ev_t e;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change dut edge %0d: got lk=%h v=%b held=%b, required no change",
                   edge_n, last_key, key_valid, key_held);
        end else begin
          e = sb.pop_front();
          if (edge_n != e.cyc || cur !== {e.lk, e.v, e.held}) begin
            n_fail++;
            $display("FAIL event%0d dut: got edge %0d lk=%h v=%b held=%b, required edge %0d lk=%h v=%b held=%b",
                     e.id, edge_n, last_key, key_valid, key_held, e.cyc, e.lk, e.v, e.held);
          end
        end
        prev = cur;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      cur1 = {last_key1, key_valid1, key_held1};
      if (cur1 !== prev1) begin
        ev_t e;
        n_checks++;
        if (sb1.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change dut1 edge %0d: got lk=%h v=%b held=%b, required no change",
                   edge_n, last_key1, key_valid1, key_held1);
        end else begin
          e = sb1.pop_front();
          if (edge_n != e.cyc || cur1 !== {e.lk, e.v, e.held}) begin
            n_fail++;
            $display("FAIL event%0d dut1: got edge %0d lk=%h v=%b held=%b, required edge %0d lk=%h v=%b held=%b",
                     e.id, edge_n, last_key1, key_valid1, key_held1, e.cyc, e.lk, e.v, e.held);
          end
        end
        prev1 = cur1;
      end
    end
  end

  initial begin
    rst            = 1'b1;
    cpu_we         = 1'b0;
    cpu_address    = 16'h0000;
    cpu_data_write = 8'h00;
    {w1, a1, s1, d1} = 4'b1111;
    // Random raw buttons while reset is held.
    {w, a, s, d} = 4'($urandom);
    step(1);
    {w, a, s, d} = 4'($urandom);
    step(2);

    n_checks += 3;
    if (last_key !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_last_key: got %h, required 00", last_key);
    end
    if (key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_key_valid: got %b, required 0", key_valid);
    end
    if (key_held !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_key_held: got %b, required 0000", key_held);
    end

    rst          = 1'b0;
    {w, a, s, d} = 4'b1111;
    prev         = {last_key, key_valid, key_held};
    prev1        = {last_key1, key_valid1, key_held1};
    mon_en       = 1'b1;
    step(2);

    // Clean press of a: visible three edges after the first sampling edge.
    a = 1'b0;
    expect_ev(0, edge_n + 4, 8'h61, 1'b1, 4'b0100);
    step(6);

    // CPU clear while a is held; no re-press while it stays held.
    expect_ev(0, edge_n + 1, 8'h00, 1'b0, 4'b0100);
    cpu_write(16'h00FF, 8'h00);
    step(3);

    // Release a for five cycles, then press again.
    a = 1'b1;
    expect_ev(0, edge_n + 4, 8'h00, 1'b0, 4'b0000);
    step(5);
    a = 1'b0;
    expect_ev(0, edge_n + 4, 8'h61, 1'b1, 4'b0100);
    step(6);

    // One-cycle glitch on d: no output change at all.
    d = 1'b0;
    step(1);
    d = 1'b1;
    step(6);

    // Write to a neighbouring address and a read of KEY_ADDR are ignored.
    cpu_write(16'h00FE, 8'h55);
    cpu_address = 16'h00FF;
    step(3);

    // Release a, clear, then press w and s together.
    a = 1'b1;
    expect_ev(0, edge_n + 4, 8'h61, 1'b1, 4'b0000);
    step(6);
    expect_ev(0, edge_n + 1, 8'h00, 1'b0, 4'b0000);
    cpu_write(16'h00FF, 8'h00);
    step(2);
    w = 1'b0;
    s = 1'b0;
    expect_ev(0, edge_n + 4, 8'h77, 1'b1, 4'b1010);
    step(6);
    w = 1'b1;
    s = 1'b1;
    expect_ev(0, edge_n + 4, 8'h77, 1'b1, 4'b0000);
    step(6);

    // Press event lands on the same edge as a clear: press wins.
    d = 1'b0;
    expect_ev(0, edge_n + 4, 8'h64, 1'b1, 4'b0001);
    step(3);
    cpu_write(16'h00FF, 8'h00);
    step(3);

    // Clear, then a non-zero write through the CPU path.
    expect_ev(0, edge_n + 1, 8'h00, 1'b0, 4'b0001);
    cpu_write(16'h00FF, 8'h00);
    step(2);
    expect_ev(0, edge_n + 1, 8'h5A, 1'b0, 4'b0001);
    cpu_write(16'h00FF, 8'h5A);

    // Reset mid-debounce of a, with d held through reset.
    a = 1'b0;
    step(2);
    rst = 1'b1;
    expect_ev(0, edge_n + 1, 8'h00, 1'b0, 4'b0000);
    step(2);
    rst = 1'b0;
    // a and d re-debounce together after reset; a outranks d.
    expect_ev(0, edge_n + 4, 8'h61, 1'b1, 4'b0101);
    step(6);

    // DEBOUNCE=1 instance: press lands one edge sooner.
    s1 = 1'b0;
    expect_ev(1, edge_n + 3, 8'h73, 1'b1, 4'b0010);
    step(6);

    n_checks += 2;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events dut: %0d expected events never seen, required 0", sb.size());
    end
    if (sb1.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events dut1: %0d expected events never seen, required 0", sb1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
